// File: rtl/tiny86_pkg.sv
// Shared constants and enums for the tiny86 trace step sequencer.
package tiny86_pkg;

  localparam int STEP_W   = 560;
  localparam int REGS_W   = 320;
  localparam int REGS_LSB = 96;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAIL
  } seq_state_t;

  typedef enum logic [1:0] {
    FAIL_NONE           = 2'd0,
    FAIL_CORE_REJECT    = 2'd1,
    FAIL_CHAIN_MISMATCH = 2'd2,
    FAIL_TIMEOUT        = 2'd3
  } seq_fail_t;

endpackage

// File: rtl/step_prefetch_buf.sv
// One-entry prefetch register (NXT) between the trace source and the sequencer FSM.
module step_prefetch_buf #(
  parameter int STEP_W = 560
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STEP_W-1:0] in_step,
  input  logic              in_last,
  input  logic              block,
  input  logic              pop,
  output logic              nxt_valid,
  output logic [STEP_W-1:0] nxt_step,
  output logic              nxt_last
);

  logic take;

  // Only refill when empty, so a load and a pop never collide.
  assign in_ready = !nxt_valid && !block;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_valid <= 1'b0;
      nxt_step  <= '0;
      nxt_last  <= 1'b0;
    end else if (take) begin
      nxt_valid <= 1'b1;
      nxt_step  <= in_step;
      nxt_last  <= in_last;
    end else if (pop) begin
      nxt_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/trace_step_sequencer.sv
// Feeds trace steps to the tiny86 step core, chain-checks register state between steps
// and reports a verdict. Optional watchdog enabled by defining TRACE_SEQ_TIMEOUT_EN.
module trace_step_sequencer #(
  parameter int STEP_W   = tiny86_pkg::STEP_W,
  parameter int REGS_LSB = tiny86_pkg::REGS_LSB,
  parameter int REGS_W   = tiny86_pkg::REGS_W,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STEP_W-1:0] in_step,
  input  logic              in_last,
  output logic [STEP_W-1:0] core_step,
  output logic              core_valid,
  input  logic              core_done,
  input  logic              core_ok,
  input  logic [REGS_W-1:0] core_next_regs,
  output logic              seq_done,
  output logic              seq_pass,
  output logic [1:0]        seq_fail_code,
  output logic [CNT_W-1:0]  steps_done
);

  import tiny86_pkg::*;

  seq_state_t        state, state_n;
  seq_fail_t         fail_q, fail_n;
  logic [STEP_W-1:0] cur_q;
  logic              cur_last;
  logic [REGS_W-1:0] exp_q;
  logic              have_exp;
  logic [CNT_W-1:0]  steps_q;

  logic              nxt_valid;
  logic [STEP_W-1:0] nxt_step;
  logic              nxt_last;
  logic              pop;
  logic              accept;
  logic              chain_bad;
  logic              wdog_expire;

  step_prefetch_buf #(.STEP_W(STEP_W)) u_nxt (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_step   (in_step),
    .in_last   (in_last),
    .block     (seq_done),
    .pop       (pop),
    .nxt_valid (nxt_valid),
    .nxt_step  (nxt_step),
    .nxt_last  (nxt_last)
  );

  // The first step after reset has no predecessor, so have_exp gates the compare.
  assign chain_bad = have_exp && (nxt_step[REGS_LSB +: REGS_W] != exp_q);

  if (TIMEOUT < 1) begin : g_timeout_unused
  end

`ifdef TRACE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q;

  // Held at zero outside WAIT, so it restarts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wdog_q <= '0;
    else                        wdog_q <= wdog_q + 1'b1;
  end

  assign wdog_expire = (state == S_WAIT) && (wdog_q == WD_W'(TIMEOUT - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    fail_n  = fail_q;
    pop     = 1'b0;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (nxt_valid) begin
          if (chain_bad) begin
            state_n = S_FAIL;
            fail_n  = FAIL_CHAIN_MISMATCH;
          end else begin
            pop     = 1'b1;
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        // A verdict in the same cycle as the watchdog expiry takes priority.
        if (core_done) begin
          if (!core_ok) begin
            state_n = S_FAIL;
            fail_n  = FAIL_CORE_REJECT;
          end else begin
            accept  = 1'b1;
            state_n = cur_last ? S_DONE : S_IDLE;
          end
        end else if (wdog_expire) begin
          state_n = S_FAIL;
          fail_n  = FAIL_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fail_q   <= FAIL_NONE;
      cur_q    <= '0;
      cur_last <= 1'b0;
      exp_q    <= '0;
      have_exp <= 1'b0;
      steps_q  <= '0;
    end else begin
      state  <= state_n;
      fail_q <= fail_n;
      if (pop) begin
        cur_q    <= nxt_step;
        cur_last <= nxt_last;
      end
      if (accept) begin
        exp_q    <= core_next_regs;
        have_exp <= 1'b1;
        if (steps_q != {CNT_W{1'b1}}) steps_q <= steps_q + 1'b1;
      end
    end
  end

  assign core_step     = cur_q;
  assign core_valid    = (state == S_ISSUE);
  assign seq_done      = (state == S_DONE) || (state == S_FAIL);
  assign seq_pass      = (state == S_DONE);
  assign seq_fail_code = fail_q;
  assign steps_done    = steps_q;

endmodule

// File: tb/tb_trace_step_sequencer.sv
// Randomized self-checking bench for trace_step_sequencer with a trace-level reference model.
module tb_trace_step_sequencer;

  localparam int STEP_W = 560, REGS_W = 320, REGS_LSB = 96, CNT_W = 32;
  localparam int TMO = 8, MAXN = 8, BUDGET = 300;

  logic              clk = 1'b0, rst = 1'b1;
  logic              in_valid = 1'b0, in_last = 1'b0;
  logic [STEP_W-1:0] in_step = '0;
  logic              core_done = 1'b0, core_ok = 1'b0;
  logic [REGS_W-1:0] core_next_regs = '0;
  logic              in_ready, core_valid, seq_done, seq_pass;
  logic [STEP_W-1:0] core_step;
  logic [1:0]        seq_fail_code;
  logic [CNT_W-1:0]  steps_done;

  trace_step_sequencer #(
    .STEP_W(STEP_W), .REGS_LSB(REGS_LSB), .REGS_W(REGS_W), .CNT_W(CNT_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_step(in_step),
    .in_last(in_last), .core_step(core_step), .core_valid(core_valid), .core_done(core_done),
    .core_ok(core_ok), .core_next_regs(core_next_regs), .seq_done(seq_done),
    .seq_pass(seq_pass), .seq_fail_code(seq_fail_code), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  // Trace description and observed results
  int                n_t;
  logic [STEP_W-1:0] tr [MAXN];
  logic [REGS_W-1:0] nr [MAXN];
  bit                ok_t [MAXN];
  int                gap_max = 0, dly_max = 0;
  bit                silent = 0;
  bit                stop;
  int                n_issued, done_cyc;
  logic [STEP_W-1:0] issued [MAXN];
  int                issue_cyc [MAXN];

  function automatic logic [STEP_W-1:0] rand_step();
    logic [STEP_W-1:0] v = '0;
    for (int w = 0; w < (STEP_W + 31) / 32; w++) v = (v << 32) | STEP_W'($urandom());
    return v;
  endfunction

  function automatic logic [REGS_W-1:0] rand_regs();
    logic [REGS_W-1:0] v = '0;
    for (int w = 0; w < REGS_W / 32; w++) v = (v << 32) | REGS_W'($urandom());
    return v;
  endfunction

  // fault: 0 none, 1 core rejects step fidx, 2 step fidx regs bit 0 flipped
  task automatic make_trace(input int n, input int fault, input int fidx);
    n_t = n;
    for (int i = 0; i < n; i++) begin
      nr[i]   = rand_regs();
      ok_t[i] = 1'b1;
      tr[i]   = rand_step();
      if (i > 0) tr[i][REGS_LSB +: REGS_W] = nr[i-1];
    end
    if (fault == 1) ok_t[fidx] = 1'b0;
    if (fault == 2) tr[fidx][REGS_LSB] = ~tr[fidx][REGS_LSB];
  endtask

  // Walks the trace in order: the first disagreement (chain or core) ends it.
  function automatic void model(output bit pass, output int code, output int steps,
                                output int iss);
    bit ended = 0;
    pass = 0; code = 0; steps = 0; iss = 0;
    for (int i = 0; i < n_t; i++) begin
      if (!ended) begin
        if (i > 0 && tr[i][REGS_LSB +: REGS_W] != nr[i-1]) begin
          code = 2; ended = 1;
        end else begin
          iss++;
          if (!ok_t[i]) begin
            code = 1; ended = 1;
          end else begin
            steps++;
            if (i == n_t - 1) pass = 1;
          end
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; core_done = 1'b0; core_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_trace();
    stop = 0; n_issued = 0; done_cyc = -1;
    fork
      begin : src
        for (int i = 0; i < n_t && !stop; i++) begin
          bit acc = 0;
          repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
          in_valid = 1'b1; in_step = tr[i]; in_last = (i == n_t - 1);
          while (!stop && !acc) begin
            @(negedge clk);
            if (in_ready) acc = 1;
          end
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
      end
      begin : core
        while (!stop) begin
          @(negedge clk);
          if (core_valid && n_issued < MAXN) begin
            int idx = n_issued;
            issued[idx]    = core_step;
            issue_cyc[idx] = cyc;
            n_issued++;
            if (!silent) begin
              @(posedge clk); #1;
              repeat ($urandom_range(0, dly_max)) begin @(posedge clk); #1; end
              core_done = 1'b1; core_ok = ok_t[idx]; core_next_regs = nr[idx];
              @(posedge clk); #1;
              core_done = 1'b0; core_ok = 1'b0;
            end
          end
        end
      end
      begin : mon
        int b = 0;
        while (!seq_done && b < BUDGET) begin @(negedge clk); b++; end
        if (seq_done) done_cyc = cyc;
        repeat (4) @(negedge clk);
        stop = 1;
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset.in_ready got=%b want=1", in_ready); end
    total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL reset.core_valid got=%b want=0", core_valid); end
    total++; if (core_step !== '0) begin bad++; $display("FAIL reset.core_step got=%h want=0", core_step); end
    total++; if (seq_done !== 1'b0 || seq_pass !== 1'b0) begin bad++; $display("FAIL reset.done_pass got=%b%b want=00", seq_done, seq_pass); end
    total++; if (seq_fail_code !== 2'd0) begin bad++; $display("FAIL reset.code got=%0d want=0", seq_fail_code); end
    total++; if (steps_done !== '0) begin bad++; $display("FAIL reset.steps got=%0d want=0", steps_done); end
  endtask

  task automatic test_single();
    do_reset();
    make_trace(1, 0, 0); gap_max = 0; dly_max = 0;
    run_trace();
    total++; if (seq_done !== 1'b1 || seq_pass !== 1'b1) begin bad++; $display("FAIL single.done_pass got=%b%b want=11", seq_done, seq_pass); end
    total++; if (steps_done !== 1) begin bad++; $display("FAIL single.steps got=%0d want=1", steps_done); end
    total++; if (n_issued !== 1) begin bad++; $display("FAIL single.issues got=%0d want=1", n_issued); end
    total++; if (issued[0] !== tr[0]) begin bad++; $display("FAIL single.payload got=%h want=%h", issued[0], tr[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    make_trace(3, 0, 0); gap_max = 0; dly_max = 0;
    run_trace();
    total++; if (seq_pass !== 1'b1 || steps_done !== 3) begin bad++; $display("FAIL b2b.result got pass=%b steps=%0d want pass=1 steps=3", seq_pass, steps_done); end
    total++; if (n_issued !== 3) begin bad++; $display("FAIL b2b.issues got=%0d want=3", n_issued); end
    else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (issue_cyc[i] - issue_cyc[i-1] !== 3) begin bad++; $display("FAIL b2b.spacing[%0d] got=%0d want=3", i, issue_cyc[i] - issue_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_chain_mismatch();
    do_reset();
    make_trace(3, 2, 1); gap_max = 1; dly_max = 1;
    run_trace();
    total++; if (seq_done !== 1'b1 || seq_pass !== 1'b0) begin bad++; $display("FAIL chain.done_pass got=%b%b want=10", seq_done, seq_pass); end
    total++; if (seq_fail_code !== 2'd2) begin bad++; $display("FAIL chain.code got=%0d want=2", seq_fail_code); end
    total++; if (steps_done !== 1) begin bad++; $display("FAIL chain.steps got=%0d want=1", steps_done); end
    total++; if (n_issued !== 1) begin bad++; $display("FAIL chain.issues got=%0d want=1", n_issued); end
  endtask

  task automatic test_core_reject();
    do_reset();
    make_trace(2, 1, 0); gap_max = 0; dly_max = 2;
    run_trace();
    total++; if (seq_fail_code !== 2'd1) begin bad++; $display("FAIL reject.code got=%0d want=1", seq_fail_code); end
    total++; if (seq_done !== 1'b1 || seq_pass !== 1'b0) begin bad++; $display("FAIL reject.done_pass got=%b%b want=10", seq_done, seq_pass); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reject.in_ready got=%b want=0", in_ready); end
    total++; if (steps_done !== 0) begin bad++; $display("FAIL reject.steps got=%0d want=0", steps_done); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      int n, fault, fidx, e_code, e_steps, e_iss;
      bit e_pass;
      n = $urandom_range(1, 6);
      fault = $urandom_range(0, 3);
      if (fault == 3 || (fault == 2 && n < 2)) fault = 0;
      fidx = (fault == 2) ? $urandom_range(1, n - 1) : $urandom_range(0, n - 1);
      do_reset();
      make_trace(n, fault, fidx); gap_max = 2; dly_max = 3;
      model(e_pass, e_code, e_steps, e_iss);
      run_trace();
      total++; if (seq_done !== 1'b1) begin bad++; $display("FAIL rand%0d.done got=%b want=1", t, seq_done); end
      total++; if (seq_pass !== e_pass) begin bad++; $display("FAIL rand%0d.pass got=%b want=%b", t, seq_pass, e_pass); end
      total++; if (seq_fail_code !== 2'(e_code)) begin bad++; $display("FAIL rand%0d.code got=%0d want=%0d", t, seq_fail_code, e_code); end
      total++; if (steps_done !== CNT_W'(e_steps)) begin bad++; $display("FAIL rand%0d.steps got=%0d want=%0d", t, steps_done, e_steps); end
      total++; if (n_issued !== e_iss) begin bad++; $display("FAIL rand%0d.issues got=%0d want=%0d", t, n_issued, e_iss); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rand%0d.in_ready got=%b want=0", t, in_ready); end
      for (int i = 0; i < n_issued && i < e_iss; i++) begin
        total++;
        if (issued[i] !== tr[i]) begin bad++; $display("FAIL rand%0d.payload[%0d] got=%h want=%h", t, i, issued[i], tr[i]); end
      end
    end
  endtask

`ifdef TRACE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    make_trace(1, 0, 0); gap_max = 0; silent = 1;
    run_trace();
    silent = 0;
    total++; if (seq_fail_code !== 2'd3) begin bad++; $display("FAIL timeout.code got=%0d want=3", seq_fail_code); end
    total++; if (n_issued !== 1 || done_cyc - issue_cyc[0] !== TMO + 1) begin bad++; $display("FAIL timeout.latency got=%0d want=%0d", done_cyc - issue_cyc[0], TMO + 1); end
    total++; if (steps_done !== 0) begin bad++; $display("FAIL timeout.steps got=%0d want=0", steps_done); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    logic [REGS_W-1:0] r;
    do_reset();
    r = rand_regs();
    in_valid = 1'b1; in_step = rand_step(); in_last = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 20 && !core_valid; k++) @(negedge clk);
    total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL midwait.issue1 got=%b want=1", core_valid); end
    @(posedge clk); #1 core_done = 1'b1; core_ok = 1'b1; core_next_regs = r;
    @(posedge clk); #1 core_done = 1'b0; core_ok = 1'b0;
    in_valid = 1'b1; in_step = rand_step(); in_step[REGS_LSB +: REGS_W] = r;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 20 && !core_valid; k++) @(negedge clk);
    total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL midwait.issue2 got=%b want=1", core_valid); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (steps_done !== 0 || seq_done !== 1'b0 || seq_fail_code !== 2'd0) begin bad++; $display("FAIL midwait.after_rst got steps=%0d done=%b code=%0d want 0 0 0", steps_done, seq_done, seq_fail_code); end
    total++; if (core_step !== '0 || core_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midwait.outs got valid=%b ready=%b step_zero=%b want 0 1 1", core_valid, in_ready, core_step == '0); end
    @(posedge clk); #1 core_done = 1'b1; core_ok = 1'b1; core_next_regs = ~r;
    @(posedge clk); #1 core_done = 1'b0; core_ok = 1'b0;
    @(negedge clk);
    total++; if (steps_done !== 0 || core_valid !== 1'b0 || seq_done !== 1'b0) begin bad++; $display("FAIL midwait.late_done got steps=%0d valid=%b done=%b want 0 0 0", steps_done, core_valid, seq_done); end
    make_trace(1, 0, 0);
    tr[0][REGS_LSB +: REGS_W] = ~r;
    gap_max = 0; dly_max = 1;
    run_trace();
    total++; if (seq_pass !== 1'b1 || steps_done !== 1) begin bad++; $display("FAIL midwait.fresh got pass=%b steps=%0d want pass=1 steps=1", seq_pass, steps_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_chain_mismatch();
    test_core_reject();
    test_random();
`ifdef TRACE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
